// File: rtl/accum_adder_pkg.sv
// rtl/accum_adder_pkg.sv - shared state encoding and saturation limits for accum_adder
package accum_adder_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Largest positive two's complement value representable in 'width' bits.
  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Most negative two's complement value representable in 'width' bits.
  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/accum_adder_addsub_ovf.sv
// rtl/accum_adder_addsub_ovf.sv - combinational signed add/sub with overflow detect (clamps under ACCUM_SATURATE_EN)
module addsub_ovf
  import accum_adder_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] r,
  output logic             step_ovf
);

  logic [WIDTH-1:0] raw;

  // Wrapped result and signed overflow from the operand/result sign bits.
  always_comb begin
    raw      = sub ? (a - b) : (a + b);
    step_ovf = 1'b0;
    if (sub) begin
      step_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
    end else begin
      step_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
    end
  end

`ifdef ACCUM_SATURATE_EN
  // Overflow direction follows the sign of the accumulator: a negative
  // running value can only overflow downwards, a non-negative one upwards.
  always_comb begin
    r = raw;
    if (step_ovf) begin
      r = a[WIDTH-1] ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH));
    end
  end
`else
  assign r = raw;
`endif

endmodule

// File: rtl/accum_adder.sv
// rtl/accum_adder.sv - handshaked multi-operand signed accumulator (optional ACCUM_SATURATE_EN clamping)
module accum_adder
  import accum_adder_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int NUM_OPS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(NUM_OPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [WIDTH-1:0] step_sum;
  logic             step_ovf;
  logic             accept;
  logic             last_op;
  logic             flush;

  assign in_ready = (state == ACCUM) && rst_n;
  assign accept   = in_valid && in_ready;
  assign last_op  = (cnt == LAST_CNT);
  assign flush    = !rst_n || clear;

  addsub_ovf #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a       (acc),
    .b       (in_data),
    .sub     (in_sub),
    .r       (step_sum),
    .step_ovf(step_ovf)
  );

  // Next state: finish collecting on the last operand, return once the result is taken.
  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && last_op) state_next = HOLD;
      HOLD:    if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // State register; reset and clear both abandon any result in progress.
  always_ff @(posedge clk) begin
    if (flush) state <= ACCUM;
    else       state <= state_next;
  end

  // Accumulator, operand count, sticky overflow and the registered result.
  always_ff @(posedge clk) begin
    if (flush) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (state == HOLD) begin
      if (out_ready) begin
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      acc <= step_sum;
      ovf <= ovf | step_ovf;
      if (last_op) begin
        cnt       <= '0;
        out_valid <= 1'b1;
        out_sum   <= step_sum;
        out_ovf   <= ovf | step_ovf;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_accum_adder.sv
// tb/tb_accum_adder.sv - self-checking bench for accum_adder (honours ACCUM_SATURATE_EN)
module tb_accum_adder;

  localparam int W = 6;
  localparam int N = 4;
  localparam int MAXV = 31;
  localparam int MINV = -32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_ovf;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  accum_adder #(.WIDTH(W), .NUM_OPS(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: operands collected as integers, result computed with
  // plain arithmetic and range checks.
  bit m_hold = 1'b0;
  int m_acc = 0;
  int m_n = 0;
  bit m_ovf = 1'b0;
  bit m_ov = 1'b0;
  int m_os = 0;
  bit m_oo = 1'b0;

  function automatic int fold(input int v);
`ifdef ACCUM_SATURATE_EN
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
`else
    return ((v - MINV) % 64 + 64) % 64 + MINV;
`endif
  endfunction

  always @(posedge clk) begin : model
    int r;
    bit so;
    if (!rst_n || clear) begin
      m_hold <= 0; m_acc <= 0; m_n <= 0; m_ovf <= 0; m_ov <= 0; m_os <= 0; m_oo <= 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold <= 0; m_ov <= 0; m_acc <= 0; m_n <= 0; m_ovf <= 0;
      end
    end else if (in_valid) begin
      r  = in_sub ? m_acc - int'($signed(in_data)) : m_acc + int'($signed(in_data));
      so = (r > MAXV) || (r < MINV);
      r  = fold(r);
      if (m_n == N - 1) begin
        m_hold <= 1; m_ov <= 1; m_os <= r; m_oo <= m_ovf | so;
        m_acc <= r; m_n <= 0; m_ovf <= m_ovf | so;
      end else begin
        m_acc <= r; m_n <= m_n + 1; m_ovf <= m_ovf | so;
      end
    end
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", int'(in_ready), int'(!m_hold && rst_n));
      chk("out_valid", int'(out_valid), int'(m_ov));
      if (m_ov && out_valid) begin
        chk("out_sum", int'($signed(out_sum)), m_os);
        chk("out_ovf", int'(out_ovf), int'(m_oo));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit s);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = W'(d);
    in_sub   = s;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic take(input string name, input int exp_sum, input int exp_ovf);
    int k;
    k = 0;
    while (!out_valid && k < 50) begin
      step();
      k++;
    end
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_sum"}, int'($signed(out_sum)), exp_sum);
    chk({name, "_ovf"}, int'(out_ovf), exp_ovf);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  int held_sum;

  initial begin
    step();
    started = 1'b1;
    step();
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_sum", int'(out_sum), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", int'(in_ready), 1);
    step();

    // 1: back-to-back adds, result one cycle after last accept
    send(5, 0); send(7, 0); send(10, 0); send(3, 0);
    chk("t1_latency", int'(out_valid), 1);
    take("t1", 25, 0);

    // 2: positive overflow
`ifdef ACCUM_SATURATE_EN
    send(20, 0); send(20, 0); send(0, 0); send(0, 0);
    take("t2", 31, 1);
`else
    send(20, 0); send(20, 0); send(0, 0); send(0, 0);
    take("t2", -24, 1);
`endif

    // 3: subtraction going negative
    send(10, 0); send(15, 1); send(0, 0); send(0, 0);
    take("t3", -5, 0);

    // 4: result held under backpressure, operands refused
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    held_sum = int'($signed(out_sum));
    chk("t4_sum", held_sum, 10);
    in_valid = 1'b1;
    in_data  = W'(7);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", int'(out_valid), 1);
      chk("t4_hold_sum", int'($signed(out_sum)), held_sum);
      chk("t4_hold_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_drop_valid", int'(out_valid), 0);
    chk("t4_in_ready", int'(in_ready), 1);

    // 5: clear discards a partial result
    send(9, 0); send(9, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    take("t5", 4, 0);

    // 6: reset during HOLD drops the result
    send(2, 0); send(2, 0); send(2, 0); send(2, 0);
    chk("t6_held", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_in_ready_rst", int'(in_ready), 0);
    step();
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_out_sum", int'(out_sum), 0);
    rst_n = 1'b1;
    #1;
    chk("t6_in_ready_rel", int'(in_ready), 1);

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      in_sub    = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
